// File: rtl/down_counter_ctrl_if.sv
// Controller-side bundle for down_counter_ctrl: start/ack handshake, load/floor
// operands and count/status outputs. The controller uses master; the counter uses slave.
interface down_counter_ctrl_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic [SIZE-1:0] load_value;
    logic [SIZE-1:0] floor_value;
    logic            enable;
    logic            ack;
    logic [SIZE-1:0] data;
    logic            bo;
    logic            busy;
    logic            done;

    modport master (
        output start, load_value, floor_value, enable, ack,
        input  data, bo, busy, done
    );

    modport slave (
        input  start, load_value, floor_value, enable, ack,
        output data, bo, busy, done
    );
endinterface

// File: rtl/down_counter_ctrl.sv
// Loadable down-counter with start/done handshake, counting from load_value to floor_value.
// Optional DOWN_COUNTER_CTRL_AUTORELOAD_EN: reload at floor with a one-cycle done pulse.
module down_counter_ctrl #(
    parameter int SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    down_counter_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            at_floor;

    // floor_value is compared live so mid-run changes apply on the next cycle
    assign at_floor = (data_q == bus.floor_value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.load_value;
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef DOWN_COUNTER_CTRL_AUTORELOAD_EN
                if (bus.start) begin
                    state_d = IDLE;
                end else if (bus.enable) begin
                    if (at_floor) begin
                        data_d = bus.load_value;
                        done_d = 1'b1;
                    end else begin
                        data_d = data_q - SIZE'(1);
                    end
                end
`else
                if (bus.enable) begin
                    if (at_floor) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end else begin
                        data_d = data_q - SIZE'(1);
                    end
                end
`endif
            end
            HOLD: begin
`ifdef DOWN_COUNTER_CTRL_AUTORELOAD_EN
                state_d = IDLE;
`else
                // ack wins over a simultaneous start: return to IDLE without reload
                if (bus.ack) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data = data_q;
    assign bus.bo   = at_floor;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;

endmodule
